// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the parallel-to-serial shift feeder:
//   DEFAULT_WIDTH - default word width / downstream shift-register length
//   state_t       - feeder FSM state encoding (IDLE, SHIFT, DONE)
// -----------------------------------------------------------------------------
package shift_pkg;

  localparam int DEFAULT_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_feeder.sv
// -----------------------------------------------------------------------------
// shift_feeder
// Accepts a parallel word plus a direction and plays it out one bit per cycle
// to a downstream shift register, so that the downstream register holds the
// word exactly once the last bit has been shifted in.
//
// Ports
//   clk       in   sole clock, rising edge
//   rst       in   synchronous active-high reset
//   in_valid  in   parallel word offered
//   in_ready  out  feeder can accept a word (IDLE only)
//   in_data   in   [WIDTH-1:0] word to serialise
//   in_dir    in   0 = left shift (MSB first), 1 = right shift (LSB first)
//   sd_bit    out  serial bit to downstream data_in
//   sd_en     out  shift enable to downstream en
//   sd_dir    out  direction to downstream dir
//   done      out  one-cycle pulse after the last bit
//   busy      out  high whenever the state is not IDLE
//
// All outputs come straight from flops. They are loaded from the *next*
// state/counter/word values so that they line up with the state they
// describe without any input-to-output combinational path.
// -----------------------------------------------------------------------------
module shift_feeder
  import shift_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dir,
  output logic             sd_bit,
  output logic             sd_en,
  output logic             sd_dir,
  output logic             done,
  output logic             busy
);

  // Counter is wide enough to hold WIDTH; it stops at WIDTH-1 and never wraps.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);

  state_t           state_r, state_nxt;
  logic [CW-1:0]    cnt_r, cnt_nxt;
  logic [WIDTH-1:0] word_r, word_nxt;
  logic             dir_r, dir_nxt;

  logic sd_bit_nxt, sd_en_nxt, sd_dir_nxt, done_nxt, busy_nxt, in_ready_nxt;

  // Bit presented for count c: MSB-first for left shift, LSB-first for right.
  function automatic logic pick_bit(input logic [WIDTH-1:0] w,
                                    input logic             d,
                                    input logic [CW-1:0]    c);
    logic [CW-1:0]    idx;
    logic [WIDTH-1:0] sh;
    if (d) begin
      idx = c;
    end else begin
      idx = CNT_LAST - c;
    end
    sh = w >> idx;
    return sh[0];
  endfunction

  // State register: FSM state, bit counter and latched word/direction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      word_r  <= '0;
      dir_r   <= 1'b0;
    end else begin
      state_r <= state_nxt;
      cnt_r   <= cnt_nxt;
      word_r  <= word_nxt;
      dir_r   <= dir_nxt;
    end
  end

  // Next-state logic: word/dir only load on acceptance, so inputs seen in
  // SHIFT or DONE can never disturb the word being played out.
  always_comb begin
    state_nxt = state_r;
    cnt_nxt   = cnt_r;
    word_nxt  = word_r;
    dir_nxt   = dir_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_nxt = SHIFT;
          cnt_nxt   = '0;
          word_nxt  = in_data;
          dir_nxt   = in_dir;
        end else begin
          state_nxt = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_r == CNT_LAST) begin
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt_r + CNT_ONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output decode from the next-state values, ahead of the output flops.
  always_comb begin
    sd_en_nxt    = 1'b0;
    sd_bit_nxt   = 1'b0;
    sd_dir_nxt   = 1'b0;
    done_nxt     = 1'b0;
    busy_nxt     = 1'b1;
    in_ready_nxt = 1'b0;
    case (state_nxt)
      IDLE: begin
        busy_nxt     = 1'b0;
        in_ready_nxt = 1'b1;
      end
      SHIFT: begin
        sd_en_nxt  = 1'b1;
        sd_bit_nxt = pick_bit(word_nxt, dir_nxt, cnt_nxt);
        sd_dir_nxt = dir_nxt;
      end
      DONE: begin
        done_nxt = 1'b1;
      end
      default: begin
        busy_nxt = 1'b0;
      end
    endcase
  end

  // Output register; reset leaves the feeder idle and ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      sd_en    <= 1'b0;
      sd_bit   <= 1'b0;
      sd_dir   <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      sd_en    <= sd_en_nxt;
      sd_bit   <= sd_bit_nxt;
      sd_dir   <= sd_dir_nxt;
      done     <= done_nxt;
      busy     <= busy_nxt;
      in_ready <= in_ready_nxt;
    end
  end

endmodule

// File: tb/tb_shift_feeder.sv
// -----------------------------------------------------------------------------
// tb_shift_feeder
// Drives shift_feeder (WIDTH=5) into a 5-bit downstream shift register and
// checks the serial stream, handshake timing and reset behaviour. Inputs are
// driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_shift_feeder;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_dir;
  logic         sd_bit;
  logic         sd_en;
  logic         sd_dir;
  logic         done;
  logic         busy;

  logic [W-1:0] ds = '0;

  int n_cmp = 0;
  int n_err = 0;

  shift_feeder #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_dir   (in_dir),
    .sd_bit   (sd_bit),
    .sd_en    (sd_en),
    .sd_dir   (sd_dir),
    .done     (done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Downstream consumer: dir=0 shifts left (new bit at LSB), dir=1 right.
  always_ff @(posedge clk) begin
    if (sd_en) begin
      if (sd_dir) ds <= {sd_bit, ds[W-1:1]};
      else        ds <= {ds[W-2:0], sd_bit};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: k-th serial bit packed at position W-1-k (first bit leftmost).
  function automatic logic [W-1:0] model_seq(input logic [W-1:0] data, input logic d);
    logic [W-1:0] s;
    for (int k = 0; k < W; k++) begin
      s[W-1-k] = 1'((data >> (d ? k : (W - 1 - k))) & 5'd1);
    end
    return s;
  endfunction

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check({tag, "_ready_timeout"}, 32'(in_ready), 32'd1);
  endtask

  // One full word: accept, W enabled bits, one DONE cycle, back to IDLE.
  task automatic run_word(input logic [W-1:0] data, input logic d,
                          input logic [W-1:0] junk, input logic [W-1:0] exp_seq,
                          input string tag);
    wait_ready(tag);
    in_valid = 1'b1;
    in_data  = data;
    in_dir   = d;
    @(negedge clk);
    in_valid = 1'b1;   // still high: must be ignored while shifting
    in_data  = junk;
    in_dir   = ~d;
    for (int k = 0; k < W; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 1) in_valid = 1'b0;
      check({tag, "_sd_en"},    32'(sd_en),    32'd1);
      check({tag, "_sd_bit"},   32'(sd_bit),   32'(exp_seq[W-1-k]));
      check({tag, "_sd_dir"},   32'(sd_dir),   32'(d));
      check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
      check({tag, "_done_lo"},  32'(done),     32'd0);
    end
    @(negedge clk);
    check({tag, "_done"},     32'(done),   32'd1);
    check({tag, "_en_off"},   32'(sd_en),  32'd0);
    check({tag, "_bit_zero"}, 32'(sd_bit), 32'd0);
    check({tag, "_busy_d"},   32'(busy),   32'd1);
    check({tag, "_ds"},       32'(ds),     32'(data));
    @(negedge clk);
    check({tag, "_done_end"},  32'(done),     32'd0);
    check({tag, "_ready_end"}, 32'(in_ready), 32'd1);
    check({tag, "_busy_end"},  32'(busy),     32'd0);
  endtask

  typedef struct {
    logic [W-1:0] data;
    logic         dir;
    logic [W-1:0] junk;
    logic [W-1:0] exp_seq;
  } vec_t;

  vec_t vt[6];

  logic en_tr[14];
  logic bit_tr[14];
  logic done_tr[14];
  logic [W-1:0] ds_tr[14];

  initial begin
    int rise1, rise2, gap, dcnt;
    logic [W-1:0] seq2;
    logic [W-1:0] rd, rj;
    logic         rdir;

    // Hand-derived expected serial streams, first bit leftmost.
    vt[0] = '{5'b10110, 1'b0, 5'b00000, 5'b10110};
    vt[1] = '{5'b10110, 1'b1, 5'b01001, 5'b01101};
    vt[2] = '{5'b00101, 1'b0, 5'b11111, 5'b00101};
    vt[3] = '{5'b11000, 1'b1, 5'b00111, 5'b00011};
    vt[4] = '{5'b00001, 1'b1, 5'b11110, 5'b10000};
    vt[5] = '{5'b11111, 1'b0, 5'b00000, 5'b11111};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_dir = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_sd_en",  32'(sd_en),  32'd0);
    check("rst_sd_bit", 32'(sd_bit), 32'd0);
    check("rst_sd_dir", 32'(sd_dir), 32'd0);
    check("rst_done",   32'(done),   32'd0);
    check("rst_busy",   32'(busy),   32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(in_ready), 32'd1);
    check("post_rst_busy",  32'(busy),     32'd0);

    for (int i = 0; i < 6; i++) begin
      run_word(vt[i].data, vt[i].dir, vt[i].junk, vt[i].exp_seq, $sformatf("vec%0d", i));
    end

    // Back-to-back: in_valid held high, 00001 then 11000 (both left shift).
    wait_ready("b2b");
    in_valid = 1'b1; in_data = 5'b00001; in_dir = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      en_tr[i] = sd_en; bit_tr[i] = sd_bit; done_tr[i] = done; ds_tr[i] = ds;
      if (i == 0) in_data = 5'b11000;
    end
    in_valid = 1'b0;
    rise1 = -1; rise2 = -1; gap = 0; dcnt = 0;
    for (int i = 0; i < 14; i++) begin
      if (en_tr[i] && (i == 0 || !en_tr[i-1])) begin
        if (rise1 < 0) rise1 = i;
        else if (rise2 < 0) rise2 = i;
      end
    end
    for (int i = 0; i < 14; i++) begin
      if (rise1 >= 0 && rise2 > rise1 && i > rise1 && i < rise2) begin
        if (!en_tr[i]) gap++;
        if (done_tr[i]) dcnt++;
      end
    end
    check("b2b_first_rise", 32'(rise1), 32'd0);
    check("b2b_spacing",    32'(rise2 - rise1), 32'(W + 2));
    // Seven-cycle spacing with five enabled cycles leaves DONE plus one IDLE cycle low.
    check("b2b_en_gap",     32'(gap),  32'd2);
    check("b2b_done_in_gap", 32'(dcnt), 32'd1);
    seq2 = '0;
    if (rise2 >= 0 && rise2 + W <= 14) begin
      for (int k = 0; k < W; k++) seq2[W-1-k] = bit_tr[rise2 + k];
    end
    check("b2b_second_seq", 32'(seq2), 32'(5'b11000));
    check("b2b_first_ds",   32'(ds_tr[5]),  32'(5'b00001));
    check("b2b_second_ds",  32'(ds_tr[12]), 32'(5'b11000));
    @(negedge clk);
    @(negedge clk);
    check("b2b_no_third", 32'(busy), 32'd0);

    // Reset after the third enabled bit.
    wait_ready("rstmid");
    in_valid = 1'b1; in_data = 5'b10101; in_dir = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rstmid_third_bit", 32'(sd_en), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_en_drop", 32'(sd_en), 32'd0);
    check("rstmid_done",    32'(done),  32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_ready", 32'(in_ready), 32'd1);
    dcnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || sd_en) dcnt++;
    end
    check("rstmid_no_done", 32'(dcnt), 32'd0);

    // Reset and in_valid on the same edge: no acceptance.
    rst = 1'b1; in_valid = 1'b1; in_data = 5'b11011; in_dir = 1'b1;
    @(negedge clk);
    check("rstacc_busy", 32'(busy),  32'd0);
    check("rstacc_en",   32'(sd_en), 32'd0);
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("rstacc_busy2", 32'(busy),  32'd0);
    check("rstacc_en2",   32'(sd_en), 32'd0);

    // Randomised words with random idle gaps against the reference model.
    for (int r = 0; r < 25; r++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      rd   = W'($urandom_range(0, 31));
      rj   = W'($urandom_range(0, 31));
      rdir = 1'($urandom_range(0, 1));
      run_word(rd, rdir, rj, model_seq(rd, rdir), $sformatf("rnd%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
